axis_output_packer: RTL
=======================

Name: axis_output_packer

Overview:
- Receiving end of the accelerator's output master stream, placed between the maxpool engine output and the S2MM DMA.
- Accepts one wide beat of GROUPS*UNITS_EDGES*COPIES words with per-word keep.
- Serialises each wide beat into NUM_SUB narrow DMA beats of OUT_WORDS words, least-significant slice first.
- Carries per-byte tkeep and frame tlast through to the DMA.

Parameters:
- GROUPS, 2, number of groups
- UNITS, 8, rows per core
- COPIES, 2, copies per group
- KERNEL_H_MAX, 3, max kernel height (odd)
- WORD_WIDTH, 8, bits per word; must be 8 so word keep equals byte keep
- OUT_WORDS, 8, words per DMA beat (64-bit bus)
- IN_WORDS, GROUPS*(UNITS+KERNEL_H_MAX-1)*COPIES = 40, words per input beat (derived)
- NUM_SUB, IN_WORDS/OUT_WORDS = 5, sub-beats per input beat (derived)
- IN_WORDS must be a multiple of OUT_WORDS; elaboration fails otherwise.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tready  out  1  input ready
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_tdata  in  IN_WORDS*WORD_WIDTH  wide beat, cgu order
- s_axis_tkeep  in  IN_WORDS  per-word keep
- m_axis_tready  in  1  DMA ready
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last DMA beat of frame
- m_axis_tdata  out  OUT_WORDS*WORD_WIDTH  narrow beat
- m_axis_tkeep  out  OUT_WORDS  byte keep
- frame_count  out  16  completed output frames, wraps at 2^16

Behaviour:
- Reset (aresetn low, asynchronous) clears buf_valid, sub, frame_count and buf_last. m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1. buf_data and buf_keep are not reset.
- Reset asserted mid-frame discards the buffered beat; no partial output follows deassertion.
- State: single buffer register set holding buf_data, buf_keep, buf_last and buf_valid, plus a sub-beat counter sub (0..NUM_SUB-1).
- Output slicing: m_axis_tdata is buf_data bits [(sub+1)*OUT_WORDS*WORD_WIDTH-1 : sub*OUT_WORDS*WORD_WIDTH]. m_axis_tkeep is the matching buf_keep slice.
- m_axis_tlast = buf_last & (sub==NUM_SUB-1).
- advance = buf_valid & ((m_axis_tvalid & m_axis_tready) | ~m_axis_tvalid).
- On advance: if sub==NUM_SUB-1, sub becomes 0; otherwise sub increments by 1.
- s_axis_tready = ~buf_valid | (advance & sub==NUM_SUB-1). This is combinational from m_axis_tready and allows back-to-back beats with no bubble.
- Input accept (s_axis_tvalid & s_axis_tready) loads the buffer, sets buf_valid and forces sub to 0.
- On the final-sub advance with no simultaneous accept, buf_valid clears. If an accept occurs in the same cycle, buf_valid stays 1.
- Latency: accept in cycle N gives first m_axis_tvalid in cycle N+1.
- Throughput: NUM_SUB output beats per input beat under full m_axis_tready.
- Stall: while m_axis_tvalid & ~m_axis_tready, tdata, tkeep and tlast hold stable and sub does not change.
- frame_count increments on each handshake where m_axis_tlast=1.
- Without the optional feature, m_axis_tvalid = buf_valid.

Optional Feature:
- Macro: AXIS_PACKER_SKIP_EMPTY_EN.
- When defined: m_axis_tvalid = buf_valid & (|keep_slice | (buf_last & sub==NUM_SUB-1)).
- Sub-beats with all-zero keep are dropped and cost one idle cycle each (advance still fires).
- The final sub-beat of a tlast beat is always emitted, even if empty, so tlast reaches the DMA.
- A non-last input beat with all keep zero produces no output and frees the buffer after NUM_SUB cycles.
- When undefined: every sub-beat is emitted regardless of keep.

Test Plan:
- Reset: hold aresetn=0 with random inputs -> s_axis_tready=1, m_axis_tvalid=0, frame_count=0.
- Single beat: words 0..39, keep all ones, tlast=1, m_axis_tready=1.
  - -> 5 beats on consecutive cycles with tdata words 0-7, 8-15, ..., 32-39, keep=0xFF.
  - -> tlast only on beat 5; frame_count=1.
- Back-to-back: 3 input beats, tvalid held high, m_axis_tready=1 -> 15 contiguous output beats, no gaps.
  - s_axis_tready high only in cycles where sub==4 (plus the first cycle).
- Backpressure: m_axis_tready toggles 1,0,0,1 -> output stable during stalls; no sub-beat lost or duplicated (scoreboard).
- Skip (macro defined): keep=0x00_FF_00_00_FF (slices 0 and 3 set), tlast=1.
  - -> beats for slices 0, 3 and 4; slice 4 has keep=0x00 and tlast=1.
- Mid-frame reset: pulse aresetn low during sub=2 -> m_axis_tvalid=0 immediately; frame_count=0; next accepted beat starts at sub=0.

Source files
------------

// File: rtl/axis_output_packer_if.sv
// AXI4-Stream bundle (valid/ready/last/data/keep) shared by the packer's wide
// input side and narrow DMA side.
interface axis_output_packer_if #(
  parameter int unsigned WORDS      = 8,
  parameter int unsigned WORD_WIDTH = 8
);
  logic                        tvalid;
  logic                        tready;
  logic                        tlast;
  logic [WORDS*WORD_WIDTH-1:0] tdata;
  logic [WORDS-1:0]            tkeep;

  modport master (output tvalid, tlast, tdata, tkeep, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, output tready);
endinterface

// File: rtl/axis_output_packer.sv
// Serialises one wide maxpool output beat into NUM_SUB narrow DMA beats, LS slice first.
// Optional macro AXIS_PACKER_SKIP_EMPTY_EN drops all-zero-keep sub-beats (except the final tlast one).
module axis_output_packer #(
  parameter int unsigned GROUPS       = 2,
  parameter int unsigned UNITS        = 8,
  parameter int unsigned COPIES       = 2,
  parameter int unsigned KERNEL_H_MAX = 3,
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned OUT_WORDS    = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_output_packer_if.slave  s_axis,
  axis_output_packer_if.master m_axis,
  output logic [15:0]          frame_count
);
  localparam int unsigned IN_WORDS = GROUPS * (UNITS + KERNEL_H_MAX - 1) * COPIES;
  localparam int unsigned NUM_SUB  = IN_WORDS / OUT_WORDS;
  localparam int unsigned SUB_W    = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
  localparam int unsigned IN_BITS  = IN_WORDS * WORD_WIDTH;
  localparam int unsigned OUT_BITS = OUT_WORDS * WORD_WIDTH;
  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(NUM_SUB - 1);

  generate
    if ((IN_WORDS % OUT_WORDS) != 0 || WORD_WIDTH != 8) begin : g_bad_cfg
      $error("axis_output_packer: IN_WORDS must be a multiple of OUT_WORDS and WORD_WIDTH must be 8");
    end
  endgenerate

  logic [IN_BITS-1:0]  buf_data_q;
  logic [IN_WORDS-1:0] buf_keep_q;
  logic                buf_last_q,    buf_last_d;
  logic                buf_valid_q,   buf_valid_d;
  logic [SUB_W-1:0]    sub_q,         sub_d;
  logic [15:0]         frame_count_q, frame_count_d;

  logic [OUT_BITS-1:0]  data_slice_c;
  logic [OUT_WORDS-1:0] keep_slice_c;
  logic                 last_sub_c;
  logic                 m_tvalid_c;
  logic                 m_tlast_c;
  logic                 advance_c;
  logic                 s_tready_c;
  logic                 accept_c;

  // Constant-index mux picks the current sub-beat slice out of the buffer.
  always_comb begin
    data_slice_c = '0;
    keep_slice_c = '0;
    for (int unsigned i = 0; i < NUM_SUB; i++) begin
      if (sub_q == SUB_W'(i)) begin
        data_slice_c = buf_data_q[i*OUT_BITS +: OUT_BITS];
        keep_slice_c = buf_keep_q[i*OUT_WORDS +: OUT_WORDS];
      end
    end
  end

  assign last_sub_c = (sub_q == LAST_SUB);
  assign m_tlast_c  = buf_last_q & last_sub_c;

`ifdef AXIS_PACKER_SKIP_EMPTY_EN
  // Empty slices are swallowed, but the closing tlast slice always goes out.
  assign m_tvalid_c = buf_valid_q & ((|keep_slice_c) | m_tlast_c);
`else
  assign m_tvalid_c = buf_valid_q;
`endif

  assign advance_c  = buf_valid_q & (m_axis.tready | ~m_tvalid_c);
  assign s_tready_c = ~buf_valid_q | (advance_c & last_sub_c);
  assign accept_c   = s_axis.tvalid & s_tready_c;

  assign s_axis.tready = s_tready_c;
  assign m_axis.tvalid = m_tvalid_c;
  assign m_axis.tlast  = m_tlast_c;
  assign m_axis.tdata  = data_slice_c;
  assign m_axis.tkeep  = keep_slice_c;
  assign frame_count   = frame_count_q;

  // Next-state: accept overrides the final-sub release so back-to-back beats keep the buffer full.
  always_comb begin
    buf_valid_d   = buf_valid_q;
    buf_last_d    = buf_last_q;
    sub_d         = sub_q;
    frame_count_d = frame_count_q;
    if (advance_c) begin
      sub_d = last_sub_c ? '0 : sub_q + SUB_W'(1);
      if (last_sub_c) buf_valid_d = 1'b0;
    end
    if (accept_c) begin
      buf_valid_d = 1'b1;
      buf_last_d  = s_axis.tlast;
      sub_d       = '0;
    end
    if (m_tvalid_c & m_axis.tready & m_tlast_c) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_valid_q   <= 1'b0;
      buf_last_q    <= 1'b0;
      sub_q         <= '0;
      frame_count_q <= '0;
    end else begin
      buf_valid_q   <= buf_valid_d;
      buf_last_q    <= buf_last_d;
      sub_q         <= sub_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Payload storage carries no reset; buf_valid_q qualifies it.
  always_ff @(posedge aclk) begin
    if (accept_c) begin
      buf_data_q <= s_axis.tdata;
      buf_keep_q <= s_axis.tkeep;
    end
  end
endmodule
